event_rr_arbiter: RTL and testbench

//  Collects single-cycle event strobes from up to EVENTS sources into sticky pending bits.

---
 rtl/event_rr_arbiter_if.sv | 34 +++
 rtl/event_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_event_rr_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/event_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : event_rr_arbiter_if
// Description : Strobe inputs, mask write, event-number stream and status
//               outputs of the round-robin event arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface event_rr_arbiter_if #(
  parameter int EVENTS     = 16,
  parameter int COUNT_BITS = 4
) ();
  logic [EVENTS-1:0]     s_ev_strobe;
  logic [31:0]           s_mask_data;
  logic                  s_mask_valid;
  logic                  s_mask_ready;
  logic [COUNT_BITS-1:0] m_evno_data;
  logic                  m_evno_valid;
  logic                  m_evno_ready;
  logic [EVENTS-1:0]     pending;
  logic [7:0]            ovf_cnt;

  // Arbiter side
  modport slave (
    input  s_ev_strobe, s_mask_data, s_mask_valid, m_evno_ready,
    output s_mask_ready, m_evno_data, m_evno_valid, pending, ovf_cnt
  );

  // Event producer / router side
  modport master (
    output s_ev_strobe, s_mask_data, s_mask_valid, m_evno_ready,
    input  s_mask_ready, m_evno_data, m_evno_valid, pending, ovf_cnt
  );
endinterface
`default_nettype wire

// File: rtl/event_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : event_rr_arbiter
// Description : Latches single-cycle event strobes into sticky pending bits
//               and serialises them round-robin onto a valid/ready
//               event-number stream. Runtime enable mask and a saturating
//               coalesce counter are provided for status.
// Revision    : 1.0 - initial release
// ============================================================================
module event_rr_arbiter #(
  parameter int              EVENTS       = 16,
  parameter int              COUNT_BITS   = 4,
  parameter logic [EVENTS-1:0] RESET_ENABLE = '1
) (
  input  wire logic clk,
  input  wire logic rst,
  event_rr_arbiter_if.slave bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [EVENTS-1:0]     enable_q;
  logic [EVENTS-1:0]     pending_q, pending_d;
  logic [7:0]            ovf_q;
  logic [COUNT_BITS-1:0] rr_last_q, rr_last_d;
  logic [COUNT_BITS-1:0] data_q, data_d;

  logic                  accept_w;
  logic [EVENTS-1:0]     acc_vec_w;
  logic [EVENTS-1:0]     strobe_en_w;
  logic [EVENTS-1:0]     cand_w;
  logic                  coalesce_w;
  logic [COUNT_BITS-1:0] pick_w;

  // First set bit of vec searching last+1, last+2, ... modulo EVENTS.
  function automatic logic [COUNT_BITS-1:0] rr_pick(
    input logic [EVENTS-1:0]     vec,
    input logic [COUNT_BITS-1:0] last
  );
    logic [COUNT_BITS-1:0] pick;
    logic                  found;
    int                    idx;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= EVENTS; k++) begin
      idx = int'(last) + k;
      if (idx >= EVENTS) idx = idx - EVENTS;
      if (!found && vec[idx]) begin
        pick  = COUNT_BITS'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Handshake decode, pending next-state and coalesce detection.
  always_comb begin
    accept_w    = (state_q == ST_OFFER) && bus.m_evno_ready;
    strobe_en_w = bus.s_ev_strobe & enable_q;
    for (int i = 0; i < EVENTS; i++) begin
      acc_vec_w[i] = accept_w && (int'(data_q) == i);
    end
    // A new occurrence wins over the accept of the same bit.
    pending_d  = strobe_en_w | (pending_q & ~acc_vec_w & enable_q);
    coalesce_w = |(strobe_en_w & pending_q & ~acc_vec_w);
    // In IDLE acc_vec_w is zero, so this is simply pending_q.
    cand_w     = pending_q & ~acc_vec_w;
    pick_w     = rr_pick(cand_w, rr_last_q);
  end

  // Offer FSM: load a selection from IDLE, chain back-to-back on handshake.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    rr_last_d = rr_last_q;
    case (state_q)
      ST_IDLE: begin
        if (|cand_w) begin
          data_d    = pick_w;
          rr_last_d = pick_w;
          state_d   = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (accept_w) begin
          if (|cand_w) begin
            data_d    = pick_w;
            rr_last_d = pick_w;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pending, mask and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      enable_q  <= RESET_ENABLE;
      pending_q <= '0;
      ovf_q     <= '0;
      rr_last_q <= COUNT_BITS'(EVENTS - 1);
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_last_q <= rr_last_d;
      data_q    <= data_d;
      if (bus.s_mask_valid) enable_q <= bus.s_mask_data[EVENTS-1:0];
      if (coalesce_w && (ovf_q != 8'hFF)) ovf_q <= ovf_q + 8'd1;
    end
  end

  // Mask bits above EVENTS carry no meaning.
  generate
    if (EVENTS < 32) begin : g_mask_unused
      wire unused_mask_hi = ^bus.s_mask_data[31:EVENTS];
    end
  endgenerate

  assign bus.s_mask_ready = 1'b1;
  assign bus.m_evno_data  = data_q;
  assign bus.m_evno_valid = (state_q == ST_OFFER);
  assign bus.pending      = pending_q;
  assign bus.ovf_cnt      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_event_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_event_rr_arbiter
// Description : Scoreboard bench for event_rr_arbiter. A set-based reference
//               model predicts status and grant beats; a negedge monitor
//               compares the DUT against the queued expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_event_rr_arbiter;
  localparam int N  = 16;
  localparam int CB = 4;

  typedef struct {
    logic [N-1:0] pend;
    int           ovf;
    bit           valid;
    int           data;
  } status_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  event_rr_arbiter_if #(.EVENTS(N), .COUNT_BITS(CB)) bus ();

  event_rr_arbiter #(.EVENTS(N), .COUNT_BITS(CB), .RESET_ENABLE({N{1'b1}})) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  status_t stq[$];
  int      beatq[$];

  // Reference model state
  bit           m_known = 0;
  bit           m_valid;
  int           m_data;
  bit [N-1:0]   m_pend;
  bit [N-1:0]   m_en;
  int           m_rr;
  int           m_ovf;

  function automatic int pick(input bit [N-1:0] set, input int last);
    for (int k = 1; k <= N; k++) begin
      if (set[(last + k) % N]) return (last + k) % N;
    end
    return last;
  endfunction

  task automatic model_step(input bit [N-1:0] s, input bit mv, input bit [31:0] md,
                            input bit rdy, input bit r);
    bit         hs;
    bit         coal;
    bit [N-1:0] np;
    bit [N-1:0] cand;
    if (m_known) stq.push_back('{m_pend, m_ovf, m_valid, m_data});
    if (r) begin
      m_valid = 0; m_data = 0; m_pend = '0; m_ovf = 0;
      m_en = '1; m_rr = N - 1; m_known = 1;
      return;
    end
    if (!m_known) return;
    hs = m_valid && rdy;
    if (hs) beatq.push_back(m_data);
    coal = 0;
    for (int i = 0; i < N; i++) begin
      if (s[i] && m_en[i]) begin
        if (m_pend[i] && !(hs && m_data == i)) coal = 1;
        np[i] = 1;
      end else if (hs && m_data == i) np[i] = 0;
      else if (!m_en[i])              np[i] = 0;
      else                            np[i] = m_pend[i];
    end
    if (coal && m_ovf < 255) m_ovf++;
    cand = m_pend;
    if (hs) cand[m_data] = 0;
    if (!m_valid || hs) begin
      if (cand != 0) begin
        m_data  = pick(cand, m_rr);
        m_rr    = m_data;
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end
    m_pend = np;
    if (mv) m_en = md[N-1:0];
  endtask

  task automatic step(input bit [N-1:0] s, input bit mv, input bit [31:0] md,
                      input bit rdy, input bit r);
    @(posedge clk); #1;
    rst              = r;
    bus.s_ev_strobe  = s;
    bus.s_mask_valid = mv;
    bus.s_mask_data  = md;
    bus.m_evno_ready = rdy;
    model_step(s, mv, md, rdy, r);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step('0, 0, 0, rdy, 0);
  endtask

  // Monitor: status every cycle, grant beats on each handshake.
  initial begin
    status_t e;
    int      b;
    forever begin
      @(negedge clk);
      if (stq.size() > 0) begin
        e = stq.pop_front();
        vectors++;
        if (bus.pending !== e.pend) begin
          miscompares++;
          $display("FAIL pending: got %h expected %h at %0t", bus.pending, e.pend, $time);
        end
        vectors++;
        if (bus.ovf_cnt !== 8'(e.ovf)) begin
          miscompares++;
          $display("FAIL ovf_cnt: got %0d expected %0d at %0t", bus.ovf_cnt, e.ovf, $time);
        end
        vectors++;
        if (bus.m_evno_valid !== e.valid) begin
          miscompares++;
          $display("FAIL valid: got %b expected %b at %0t", bus.m_evno_valid, e.valid, $time);
        end
        vectors++;
        if (bus.s_mask_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL mask_ready: got %b expected 1 at %0t", bus.s_mask_ready, $time);
        end
        if (e.valid) begin
          vectors++;
          if (bus.m_evno_data !== CB'(e.data)) begin
            miscompares++;
            $display("FAIL data: got %0d expected %0d at %0t", bus.m_evno_data, e.data, $time);
          end
        end
      end
      if (m_known && !rst && bus.m_evno_valid === 1'b1 && bus.m_evno_ready === 1'b1) begin
        vectors++;
        if (beatq.size() == 0) begin
          miscompares++;
          $display("FAIL beat: got unexpected %0d expected none at %0t", bus.m_evno_data, $time);
        end else begin
          b = beatq.pop_front();
          if (bus.m_evno_data !== CB'(b)) begin
            miscompares++;
            $display("FAIL beat: got %0d expected %0d at %0t", bus.m_evno_data, b, $time);
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    bit [N-1:0] s;
    bit [31:0]  md;
    bit         mv, rdy, r;
    bus.s_ev_strobe  = '0;
    bus.s_mask_valid = 0;
    bus.s_mask_data  = '0;
    bus.m_evno_ready = 0;

    // 1: single strobe, two-cycle latency
    step('0, 0, 0, 0, 1);
    step('0, 0, 0, 0, 1);
    step(N'(1) << 3, 0, 0, 1, 0);
    idle(4, 1);

    // 2: simultaneous strobes, then wrap of rr pointer
    step((N'(1) << 1) | (N'(1) << 5) | (N'(1) << 9), 0, 0, 1, 0);
    idle(5, 1);
    step((N'(1) << 1) | (N'(1) << 5), 0, 0, 1, 0);
    idle(4, 1);

    // 3: stalled, repeated strobe coalesces
    for (int i = 0; i < 3; i++) step(N'(1) << 2, 0, 0, 0, 0);
    idle(3, 0);
    idle(4, 1);

    // 4: disabled source dropped, enabled source granted
    step('0, 1, 32'h0000_FFFE, 1, 0);
    step(N'(1) << 0, 0, 0, 1, 0);
    idle(3, 1);
    step(N'(1) << 4, 0, 0, 1, 0);
    idle(3, 1);
    step('0, 1, 32'h0000_FFFF, 1, 0);

    // 5: new strobe on the handshake cycle of the same source
    step(N'(1) << 7, 0, 0, 0, 0);
    idle(2, 0);
    step(N'(1) << 7, 0, 0, 1, 0);
    idle(4, 1);

    // 6: reset during an offer
    step(N'(16'h00F0), 0, 0, 0, 0);
    idle(2, 0);
    step('0, 0, 0, 0, 1);
    step((N'(1) << 0) | (N'(1) << 5), 0, 0, 1, 0);
    idle(5, 1);

    // Counter saturation
    for (int i = 0; i < 270; i++) step(N'(1) << 2, 0, 0, 0, 0);
    idle(4, 1);
    step('0, 0, 0, 0, 1);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      s   = N'($urandom & $urandom & $urandom);
      rdy = ($urandom_range(0, 3) != 0);
      mv  = ($urandom_range(0, 49) == 0);
      md  = $urandom | 32'hFFFF_0F0F;
      r   = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 3) == 0) s = '0;
      step(s, mv, md, rdy, r);
    end

    step('0, 1, 32'hFFFF_FFFF, 1, 0);
    idle(N + 4, 1);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (beatq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d beats outstanding expected 0", beatq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
